// File: rtl/fire7_expand1_ofm_writer.sv
// Snapshots the 192-channel expand-1x1 output vector and drains it BANKS channels
// per cycle into banked OFM RAM in channel-group-major order; flags layer completion.
module fire7_expand1_ofm_writer #(
    parameter int WOUT  = 16,
    parameter int CH    = 192,
    parameter int WIDTH = 16,
    parameter int BANKS = 4,
    localparam int GROUPS = CH / BANKS,
    localparam int AW     = $clog2(GROUPS * WOUT * WOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_i,
    input  logic [WIDTH-1:0] ofm_i [0:CH-1],
    output logic             wr_en_o,
    output logic [AW-1:0]    wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o [0:BANKS-1],
    output logic             busy_o,
    output logic             layer_done_o,
    output logic             ram_feedback_o,
    output logic             overrun_o
);

    localparam int PIX = WOUT * WOUT;
    localparam int GW  = $clog2(GROUPS);
    localparam int PW  = $clog2(PIX);
    localparam int CW  = $clog2(CH);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PIX - 1);
    localparam logic [AW-1:0] PIX_A  = AW'(PIX);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    g_q, g_d;
    logic [PW-1:0]    p_q, p_d;
    logic             accept, reject, final_wr;
    logic [CW-1:0]    idx;

    logic [WIDTH-1:0] snap_q    [0:CH-1];
    logic [WIDTH-1:0] wr_data_q [0:BANKS-1];
    logic [WIDTH-1:0] wr_data_d [0:BANKS-1];
    logic             wr_en_q, busy_q, done_q, fb_q, ovr_q;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        p_d      = p_q;
        accept   = 1'b0;
        reject   = 1'b0;
        final_wr = 1'b0;
        case (state_q)
            IDLE: accept = sample_i;
            DRAIN: begin
                if (g_q == G_LAST) begin
                    g_d = '0;
                    // The last pixel's final group closes the layer; a coincident sample is ignored.
                    if (p_q == P_LAST) begin
                        state_d  = DONE;
                        final_wr = 1'b1;
                    end else begin
                        p_d     = p_q + 1'b1;
                        state_d = IDLE;
                        accept  = sample_i;
                    end
                end else begin
                    g_d    = g_q + 1'b1;
                    reject = sample_i;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = DRAIN;
            g_d     = '0;
        end
    end

    // Outputs are registered from next-state values so the write lands the cycle after accept.
    always_comb begin
        wr_addr_d = AW'(g_d) * PIX_A + AW'(p_d);
        idx       = '0;
        for (int b = 0; b < BANKS; b++) begin
            idx          = CW'(int'(g_d) * BANKS + b);
            wr_data_d[b] = accept ? ofm_i[b] : snap_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            snap_q <= ofm_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            g_q       <= '0;
            p_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fb_q      <= 1'b0;
            ovr_q     <= 1'b0;
            for (int b = 0; b < BANKS; b++) begin
                wr_data_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            wr_en_q <= (state_d == DRAIN);
            busy_q  <= (state_d == DRAIN);
            if (state_d == DRAIN) begin
                wr_addr_q <= wr_addr_d;
                wr_data_q <= wr_data_d;
            end
            done_q <= final_wr;
            fb_q   <= fb_q | final_wr;
            ovr_q  <= ovr_q | reject;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign busy_o         = busy_q;
    assign layer_done_o   = done_q;
    assign ram_feedback_o = fb_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_fire7_expand1_ofm_writer.sv
// Randomized bench for fire7_expand1_ofm_writer: a time-based transaction model predicts
// every write, the done/feedback flags and overrun; a RAM image is checked after a full layer.
module tb_fire7_expand1_ofm_writer;

    localparam int CH = 192, W = 16, NB = 4, NG = 48, PIX = 256, NADDR = NG * PIX;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample = 1'b0;
    logic [W-1:0]  ofm [0:CH-1];
    logic          wr_en;
    logic [13:0]   wr_addr;
    logic [W-1:0]  wr_data [0:NB-1];
    logic          busy, done, fb, ovr;

    fire7_expand1_ofm_writer dut (
        .clk(clk), .rst(rst), .sample_i(sample), .ofm_i(ofm),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .busy_o(busy), .layer_done_o(done), .ram_feedback_o(fb), .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: each accepted sample schedules 48 writes on consecutive cycles.
    typedef struct { int cyc; int addr; logic [63:0] data; } wr_t;
    wr_t         q[$];
    int          m_pix = 0, m_drain_end = -1, m_done_at = -1;
    bit          m_final = 0, m_ovr = 0;
    logic [63:0] ram [0:NADDR-1];
    int          busy_cnt = 0, done_cnt = 0, wr_cnt = 0;

    always @(negedge clk) begin : mon
        logic [63:0] obs;
        bit          exp_wr;
        wr_t         e;
        int          c;
        c = cyc;
        for (int b = 0; b < NB; b++) obs[b*W +: W] = wr_data[b];
        exp_wr = (q.size() > 0) && (q[0].cyc == c);
        chk("wr_en", wr_en, exp_wr);
        chk("busy", busy, exp_wr);
        if (exp_wr) begin
            chk("wr_addr", wr_addr, q[0].addr);
            chk("wr_data", obs, q[0].data);
            void'(q.pop_front());
        end
        chk("layer_done", done, (m_done_at >= 0) && (c == m_done_at));
        chk("ram_feedback", fb, (m_done_at >= 0) && (c >= m_done_at));
        chk("overrun", ovr, m_ovr);
        if (wr_en) begin
            if (int'(wr_addr) < NADDR) ram[wr_addr] = obs;
            wr_cnt++;
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (rst) begin
            q.delete();
            m_pix = 0; m_drain_end = -1; m_done_at = -1; m_final = 0; m_ovr = 0;
        end else if (sample) begin
            if (m_final && c >= m_drain_end) begin
                // layer finished: sample ignored
            end else if (c < m_drain_end) begin
                m_ovr = 1;
            end else begin
                for (int g = 0; g < NG; g++) begin
                    e.cyc  = c + 1 + g;
                    e.addr = g * PIX + m_pix;
                    for (int b = 0; b < NB; b++) e.data[b*W +: W] = ofm[g*NB + b];
                    q.push_back(e);
                end
                m_drain_end = c + NG;
                if (m_pix == PIX - 1) begin
                    m_final   = 1;
                    m_done_at = c + NG + 1;
                end
                m_pix++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fire();
        sample = 1'b1;
        tick(1);
        sample = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic rand_ofm();
        for (int c = 0; c < CH; c++) ofm[c] = W'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        logic [63:0] obs;
        for (int b = 0; b < NB; b++) obs[b*W +: W] = wr_data[b];
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, obs, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fb"}, fb, 0);
        chk({tag, "_ovr"}, ovr, 0);
    endtask

    initial begin
        logic [63:0] exp;
        int          g, p, ch;
        for (int c = 0; c < CH; c++) ofm[c] = '0;
        tick(3);
        rst = 1'b0;
        chk_zero("reset");

        // single sample, ofm[c] = c+1
        for (int c = 0; c < CH; c++) ofm[c] = W'(c + 1);
        tick(6);
        busy_cnt = 0;
        fire();
        tick(60);
        chk("single_busy_cycles", busy_cnt, NG);

        // back-to-back at T and T+48
        do_reset();
        rand_ofm();
        fire();
        tick(47);
        rand_ofm();
        fire();
        tick(100);
        chk("b2b_overrun", ovr, 0);

        // overrun at T+20, next sample at T+100
        do_reset();
        rand_ofm();
        fire();
        tick(19);
        rand_ofm();
        fire();
        chk("ovr_next_cycle", ovr, 1);
        tick(79);
        rand_ofm();
        fire();
        tick(60);
        chk("ovr_sticky", ovr, 1);

        // reset mid-drain at T+30
        do_reset();
        rand_ofm();
        fire();
        tick(29);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_zero("mid_rst");
        tick(3);
        rand_ofm();
        fire();
        tick(60);

        // random spacing, including rejected samples
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rand_ofm();
            fire();
            tick($urandom_range(0, 70));
        end
        tick(60);

        // full layer: 256 samples every 65 cycles, ofm[c] = {k, c}
        do_reset();
        for (int a = 0; a < NADDR; a++) ram[a] = '1;
        done_cnt = 0;
        for (int k = 0; k < PIX; k++) begin
            for (int c = 0; c < CH; c++) ofm[c] = {k[7:0], c[7:0]};
            fire();
            tick(64);
        end
        tick(5);
        for (int a = 0; a < NADDR; a++) begin
            g = a / PIX;
            p = a % PIX;
            for (int b = 0; b < NB; b++) begin
                ch = g * NB + b;
                exp[b*W +: W] = {p[7:0], ch[7:0]};
            end
            chk("ram_image", ram[a], exp);
        end
        chk("full_done_pulses", done_cnt, 1);
        chk("full_feedback", fb, 1);
        chk("full_overrun", ovr, 0);

        // sample after layer completion
        wr_cnt = 0;
        rand_ofm();
        fire();
        tick(60);
        chk("post_done_writes", wr_cnt, 0);
        chk("post_done_feedback", fb, 1);
        chk("post_done_overrun", ovr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fire7_expand1_ofm_writer.md
# fire7_expand1_ofm_writer

Downstream stage of the fire7 expand-1x1 layer. It snapshots the 192-channel parallel output vector on each sample pulse and drains it, BANKS channels per cycle, into banked feature-map RAM in channel-group-major layout. After the last output pixel it raises the `ram_feedback` level that the expand layer and the next-layer controller consume.

## Interface
- `WOUT`, 16: output feature-map width/height; pixels per layer = WOUT² = 256
- `CH`, 192: channels per sample vector; equals the expand layer's DSP count
- `WIDTH`, 16: data width per channel
- `BANKS`, 4: RAM banks written in parallel; CH must be divisible by BANKS
- `GROUPS`, derived: CH/BANKS = 48
- `AW`, derived: $clog2(GROUPS*WOUT²) = 14

Ports:
- `clk`, in, 1: clock
- `rst`, in, 1: reset; synchronous, active-high
- `sample_i`, in, 1: one-cycle pulse; `ofm_i` is valid in this cycle
- `ofm_i`, in, WIDTH x [0:CH-1]: unpacked array of ReLU'd Q-format results
- `wr_en_o`, out, 1: write strobe, common to all banks
- `wr_addr_o`, out, AW: write address, common to all banks
- `wr_data_o`, out, WIDTH x [0:BANKS-1]: one word per bank
- `busy_o`, out, 1: drain in progress
- `layer_done_o`, out, 1: one-cycle pulse after the final write of the layer
- `ram_feedback_o`, out, 1: level; high from `layer_done_o` until `rst`
- `overrun_o`, out, 1: sticky; a sample arrived that could not be accepted

## Operation
- State machine states:
  - IDLE: not busy.
  - DRAIN: group counter g runs 0..GROUPS-1.
  - DONE: terminal state.
- Accept rule: `sample_i` is accepted in IDLE, or in DRAIN when g = GROUPS-1 (the last-group cycle).
  - On accept, all CH words of `ofm_i` are registered into the snapshot buffer.
  - g is reset to 0 and the FSM goes to (or stays in) DRAIN.
- Reject rule: `sample_i` in DRAIN with g < GROUPS-1 is dropped.
  - The snapshot buffer and the drain are unaffected.
  - `overrun_o` is set to 1.
- DONE behaviour: `sample_i` is ignored. No write occurs and `overrun_o` does not change.
- Write in DRAIN, per cycle:
  - `wr_en_o` = 1.
  - `wr_data_o[b]` = snapshot[g*BANKS + b]; so bank b holds channels c with c mod BANKS = b.
  - `wr_addr_o` = g*WOUT² + p, where p is the pixel counter (0..WOUT²-1). Width is exactly AW bits with no wrap.
- End of drain, at g = GROUPS-1:
  - If p < WOUT²-1: p increments. The FSM returns to IDLE, or restarts DRAIN on an accepted sample.
  - If p = WOUT²-1: the FSM goes to DONE, `layer_done_o` pulses next cycle, and `ram_feedback_o` rises with it.
  - A sample arriving in this same cycle is treated as a DONE-state sample: ignored, not an overrun.
- Data values pass through unmodified; no saturation or sign handling is done here.
- Reset values: `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0, `layer_done_o`=0, `ram_feedback_o`=0, `overrun_o`=0. Also p=0, g=0, FSM=IDLE. The snapshot buffer does not need reset.
- `rst` in any state, including mid-drain, aborts immediately. Partial writes are not retried.

## Timing
- `sample_i` high at cycle T (accepted): first write (g=0) at T+1, last write (g=GROUPS-1) at T+GROUPS = T+48.
- `busy_o` is high T+1..T+48 and equals the DRAIN state, registered.
- All outputs are registered. There is no combinational path from `sample_i` or `ofm_i` to any output.
- Back-to-back samples: minimum accepted interval is GROUPS cycles. A sample at T+48 gives writes T+49..T+96 with no gap.
- The expand layer's nominal interval is CHIN+1 = 65 cycles, so no overrun occurs in normal operation.
- Last pixel: final write at T+48, `layer_done_o`=1 at T+49 only, `ram_feedback_o`=1 from T+49 onward.

## Test plan
- Single sample after reset:
  - Stimulus: `ofm_i[c]` = c+1, `sample_i` at T=10.
  - Response: writes at cycles 11..58. `wr_addr_o` = g*256; `wr_data_o[b]` = 4g+b+1.
  - `busy_o` is high for exactly 48 cycles.
- Full layer:
  - Stimulus: 256 samples every 65 cycles; sample k carries `ofm_i[c]` = {k[7:0], c[7:0]}.
  - Response: the RAM model matches the layout at all 12288 addresses per bank.
  - `layer_done_o` pulses once, one cycle after the last write; `ram_feedback_o` stays high.
  - `overrun_o` stays 0.
- Back-to-back:
  - Stimulus: samples at T and T+48.
  - Response: 96 consecutive writes with the second pixel's addresses at g*256+1, and no `overrun_o`.
- Overrun:
  - Stimulus: a second sample at T+20.
  - Response: `overrun_o`=1 from T+21. The first drain's data is unchanged, p advances by 1 only, and the next sample at T+100 writes pixel 1.
- Post-done:
  - Stimulus: a sample after `ram_feedback_o`=1.
  - Response: no `wr_en_o`, `overrun_o` unchanged.
- Reset mid-drain:
  - Stimulus: `rst` at T+30.
  - Response: at T+31 all outputs are 0.
  - The next sample writes at addresses g*256+0, i.e. p restarted.
